i2c_sensor_target: RTL and testbench

//  I2C target (responder) emulating the 16-bit temperature/humidity sensor that i2c_master polls.

---
 rtl/i2c_sensor_target_if.sv | 22 ++
 rtl/i2c_sensor_target.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_sensor_target.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_sensor_target_if.sv
// Bus-side signals of the emulated I2C temperature/humidity sensor:
// open-drain pin view plus the measurement/command sideband.
interface i2c_sensor_target_if;
   logic        scl_in;
   logic        sda_in;
   logic        sda_out;
   logic        sda_en;
   logic [15:0] meas_in;
   logic [7:0]  cmd_data;
   logic        cmd_valid;
   logic        busy;

   modport slave (
      input  scl_in, sda_in, meas_in,
      output sda_out, sda_en, cmd_data, cmd_valid, busy
   );

   modport master (
      output scl_in, sda_in, meas_in,
      input  sda_out, sda_en, cmd_data, cmd_valid, busy
   );
endinterface

// File: rtl/i2c_sensor_target.sv
// I2C target standing in for the 16-bit sensor: oversamples SCL/SDA, ACKs its
// address, collects command bytes on writes and serves a measurement snapshot on reads.
module i2c_sensor_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h40,
   parameter int         SYNC_STAGES = 2,
   parameter int         HOLD_CYC    = 30
) (
   input logic                clk,
   input logic                rst,
   i2c_sensor_target_if.slave bus
);

   localparam int            HW        = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      RX_BYTE,
      RX_ACK,
      TX_BYTE,
      TX_ACKCHK,
      WAIT_STOP
   } state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_prev, sda_prev;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shift_reg, shift_n;
   logic [15:0]   tx_reg, tx_n;
   logic          byte_idx, byte_idx_n;
   logic          busy, busy_n;
   logic [7:0]    cmd_data, cmd_data_n;
   logic          cmd_valid, cmd_valid_n;
   logic          sda_en, sda_en_n;
   logic          pend, pend_n;
   logic          pend_val, pend_val_n;
   logic [HW-1:0] hold_cnt, hold_cnt_n;
   logic          sched, sched_val;
   logic [7:0]    cur_byte, next_byte;
   logic [2:0]    tx_pos;

   // Pins are idle-high, so the synchronizers come out of reset at 1 to avoid
   // a phantom START/STOP on the first cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         scl_prev <= scl_sync[SYNC_STAGES-1];
         sda_prev <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

   assign cur_byte  = byte_idx ? tx_reg[7:0]  : tx_reg[15:8];
   assign next_byte = byte_idx ? tx_reg[15:8] : tx_reg[7:0];
   assign tx_pos    = 3'd7 - bit_cnt[2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Protocol decode. bit_cnt tracks SCL rises within a 9-clock frame: 8 means
   // the data bits are done, 9 means the ACK clock has risen. Any SDA change is
   // only scheduled here and applied once the hold counter expires.
   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift_reg;
      tx_n        = tx_reg;
      byte_idx_n  = byte_idx;
      busy_n      = busy;
      cmd_data_n  = cmd_data;
      cmd_valid_n = 1'b0;
      sda_en_n    = sda_en;
      pend_n      = pend;
      pend_val_n  = pend_val;
      hold_cnt_n  = hold_cnt;
      sched       = 1'b0;
      sched_val   = 1'b0;

      unique case (state)
         IDLE, WAIT_STOP: begin
         end
         ADDR: begin
            if (scl_rise) begin
               shift_n   = {shift_reg[6:0], sda_s};
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  if (shift_n[7:1] == DEV_ADDR) begin
                     state_n    = ADDR_ACK;
                     tx_n       = bus.meas_in;
                     byte_idx_n = 1'b0;
                     busy_n     = 1'b1;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end
            end
         end
         ADDR_ACK: begin
            if (scl_rise && bit_cnt == 4'd8) begin
               bit_cnt_n = 4'd9;
            end else if (scl_fall && bit_cnt == 4'd8) begin
               sched     = 1'b1;
               sched_val = 1'b1;
            end else if (scl_fall && bit_cnt == 4'd9) begin
               bit_cnt_n = 4'd0;
               sched     = 1'b1;
               if (shift_reg[0]) begin
                  state_n   = TX_BYTE;
                  sched_val = ~tx_reg[15];
               end else begin
                  state_n   = RX_BYTE;
                  sched_val = 1'b0;
               end
            end
         end
         RX_BYTE: begin
            if (scl_rise) begin
               shift_n   = {shift_reg[6:0], sda_s};
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  state_n = RX_ACK;
               end
            end
         end
         RX_ACK: begin
            if (scl_rise && bit_cnt == 4'd8) begin
               bit_cnt_n = 4'd9;
            end else if (scl_fall && bit_cnt == 4'd8) begin
               sched       = 1'b1;
               sched_val   = 1'b1;
               cmd_data_n  = shift_reg;
               cmd_valid_n = 1'b1;
            end else if (scl_fall && bit_cnt == 4'd9) begin
               state_n   = RX_BYTE;
               bit_cnt_n = 4'd0;
               sched     = 1'b1;
               sched_val = 1'b0;
            end
         end
         TX_BYTE: begin
            if (scl_rise) begin
               bit_cnt_n = bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
               state_n   = TX_ACKCHK;
               sched     = 1'b1;
               sched_val = 1'b0;
            end else if (scl_fall && bit_cnt != 4'd0) begin
               sched     = 1'b1;
               sched_val = ~cur_byte[tx_pos];
            end
         end
         TX_ACKCHK: begin
            if (scl_rise && bit_cnt == 4'd8) begin
               if (sda_s) begin
                  state_n = WAIT_STOP;
               end else begin
                  bit_cnt_n = 4'd9;
               end
            end else if (scl_fall && bit_cnt == 4'd9) begin
               state_n    = TX_BYTE;
               bit_cnt_n  = 4'd0;
               byte_idx_n = ~byte_idx;
               sched      = 1'b1;
               sched_val  = ~next_byte[7];
            end
         end
      endcase

      if (sched) begin
         pend_n     = 1'b1;
         pend_val_n = sched_val;
         hold_cnt_n = HOLD_LOAD;
      end else if (pend) begin
         if (hold_cnt == '0) begin
            sda_en_n = pend_val;
            pend_n   = 1'b0;
         end else begin
            hold_cnt_n = hold_cnt - HW'(1);
         end
      end

      // START/STOP win over everything, including a pending SDA change.
      if (start_det || stop_det) begin
         state_n     = start_det ? ADDR : IDLE;
         bit_cnt_n   = 4'd0;
         sda_en_n    = 1'b0;
         pend_n      = 1'b0;
         cmd_valid_n = 1'b0;
         if (stop_det) begin
            busy_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= 4'd0;
         shift_reg <= 8'h00;
         tx_reg    <= 16'h0000;
         byte_idx  <= 1'b0;
         busy      <= 1'b0;
         cmd_data  <= 8'h00;
         cmd_valid <= 1'b0;
         sda_en    <= 1'b0;
         pend      <= 1'b0;
         pend_val  <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         bit_cnt   <= bit_cnt_n;
         shift_reg <= shift_n;
         tx_reg    <= tx_n;
         byte_idx  <= byte_idx_n;
         busy      <= busy_n;
         cmd_data  <= cmd_data_n;
         cmd_valid <= cmd_valid_n;
         sda_en    <= sda_en_n;
         pend      <= pend_n;
         pend_val  <= pend_val_n;
         hold_cnt  <= hold_cnt_n;
      end
   end

   assign bus.sda_out   = 1'b0;
   assign bus.sda_en    = sda_en;
   assign bus.cmd_data  = cmd_data;
   assign bus.cmd_valid = cmd_valid;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Open-drain I2C master BFM driving the sensor target, with a queue-based
// scoreboard fed by a transaction-level model of the sensor.
module tb_i2c_sensor_target;

   localparam int         Q         = 25;
   localparam logic [6:0] DEV       = 7'h40;
   localparam int         P_BUSY    = 0;
   localparam int         P_SDAEN   = 1;
   localparam int         P_NODRIVE = 2;
   localparam int         P_CMD     = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl_line = 1'b1;
   logic        m_sda_low = 1'b0;
   logic [15:0] meas_val = 16'h0000;

   always #5 clk = ~clk;

   i2c_sensor_target_if bus_if ();

   assign bus_if.scl_in  = scl_line;
   assign bus_if.sda_in  = ~(m_sda_low | bus_if.sda_en);
   assign bus_if.meas_in = meas_val;

   i2c_sensor_target #(
      .DEV_ADDR   (DEV),
      .SYNC_STAGES(2),
      .HOLD_CYC   (30)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   typedef struct {
      string name;
      int    sel;
      int    val;
   } probe_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cmd_q[$];
   logic [7:0] exp_rd_q[$];
   logic       exp_ack_q[$];
   probe_t     exp_probe_q[$];
   probe_t     mon_p;
   logic       rd_strobe = 1'b0;
   logic       ack_strobe = 1'b0;
   logic       probe_strobe = 1'b0;
   logic       final_strobe = 1'b0;
   logic [7:0] rd_obs = 8'h00;
   logic       ack_obs = 1'b0;
   logic       watch_nodrive = 1'b0;
   int         nodrive_hits = 0;

   logic [15:0] model_snap = 16'h0000;
   logic        model_idx = 1'b0;

   task automatic score(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // The only process that compares: pops an expectation whenever the DUT or
   // the BFM presents something.
   always @(negedge clk) begin
      if (watch_nodrive && bus_if.sda_en) nodrive_hits++;
      if (bus_if.cmd_valid) begin
         if (exp_cmd_q.size() == 0) score("cmd_valid_unexpected", int'(bus_if.cmd_data), -1);
         else score("cmd_data", int'(bus_if.cmd_data), int'(exp_cmd_q.pop_front()));
      end
      if (rd_strobe) begin
         if (exp_rd_q.size() == 0) score("read_unexpected", int'(rd_obs), -1);
         else score("read_byte", int'(rd_obs), int'(exp_rd_q.pop_front()));
      end
      if (ack_strobe) begin
         if (exp_ack_q.size() == 0) score("ack_unexpected", int'(ack_obs), -1);
         else score("target_ack", int'(ack_obs), int'(exp_ack_q.pop_front()));
      end
      if (probe_strobe) begin
         if (exp_probe_q.size() == 0) begin
            score("probe_unexpected", 1, 0);
         end else begin
            mon_p = exp_probe_q.pop_front();
            case (mon_p.sel)
               P_BUSY:    score(mon_p.name, int'(bus_if.busy), mon_p.val);
               P_SDAEN:   score(mon_p.name, int'(bus_if.sda_en), mon_p.val);
               P_NODRIVE: score(mon_p.name, nodrive_hits, mon_p.val);
               default:   score(mon_p.name, int'(bus_if.cmd_data), mon_p.val);
            endcase
         end
      end
      if (final_strobe) begin
         score("cmd_queue_left", exp_cmd_q.size(), 0);
         score("read_queue_left", exp_rd_q.size(), 0);
         score("ack_queue_left", exp_ack_q.size(), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitq();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int sel, input int exp);
      exp_probe_q.push_back('{name: name, sel: sel, val: exp});
      probe_strobe = 1'b1;
      tick();
      probe_strobe = 1'b0;
   endtask

   task automatic presentAck(input logic a);
      ack_obs    = a;
      ack_strobe = 1'b1;
      tick();
      ack_strobe = 1'b0;
   endtask

   task automatic presentRd(input logic [7:0] d);
      rd_obs    = d;
      rd_strobe = 1'b1;
      tick();
      rd_strobe = 1'b0;
   endtask

   task automatic i2cStart();
      m_sda_low = 1'b0;
      waitq();
      scl_line = 1'b1;
      waitq();
      m_sda_low = 1'b1;
      waitq();
      scl_line = 1'b0;
      waitq();
   endtask

   task automatic i2cStop();
      m_sda_low = 1'b1;
      waitq();
      scl_line = 1'b1;
      waitq();
      m_sda_low = 1'b0;
      waitq();
      waitq();
   endtask

   task automatic writeBit(input logic b);
      m_sda_low = ~b;
      waitq();
      scl_line = 1'b1;
      waitq();
      waitq();
      scl_line = 1'b0;
      waitq();
   endtask

   task automatic readBit(output logic b);
      m_sda_low = 1'b0;
      waitq();
      scl_line = 1'b1;
      waitq();
      b = bus_if.sda_in;
      waitq();
      scl_line = 1'b0;
      waitq();
   endtask

   task automatic writeByte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) writeBit(d[i]);
      readBit(b);
      ack = ~b;
   endtask

   task automatic readByte(input logic master_ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         readBit(b);
         d[i] = b;
      end
      writeBit(~master_ack);
   endtask

   // Sensor model: a hit snapshots the current measurement; reads walk its
   // bytes high, low, high, ... and every write byte becomes a command.
   task automatic sendAddr(input logic [6:0] addr, input logic rw, output logic hit);
      logic ack;
      hit = (addr == DEV);
      exp_ack_q.push_back(hit);
      if (hit) begin
         model_snap = meas_val;
         model_idx  = 1'b0;
      end
      writeByte({addr, rw}, ack);
      presentAck(ack);
   endtask

   task automatic sendData(input logic [7:0] d);
      logic ack;
      exp_cmd_q.push_back(d);
      exp_ack_q.push_back(1'b1);
      writeByte(d, ack);
      presentAck(ack);
   endtask

   task automatic recvData(input logic master_ack);
      logic [7:0] d;
      exp_rd_q.push_back(model_idx ? model_snap[7:0] : model_snap[15:8]);
      if (master_ack) model_idx = ~model_idx;
      readByte(master_ack, d);
      presentRd(d);
   endtask

   task automatic applyStimulus(input logic is_read, input logic [6:0] addr, input int n);
      logic hit;
      i2cStart();
      sendAddr(addr, is_read, hit);
      if (hit) begin
         for (int i = 0; i < n; i++) begin
            if (is_read) recvData(i != n - 1);
            else sendData(8'($urandom));
         end
      end
      i2cStop();
      checkOutput("busy_after_stop", P_BUSY, 0);
   endtask

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic hit;
      rst = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      tick();
      checkOutput("reset_busy", P_BUSY, 0);
      checkOutput("reset_sda_en", P_SDAEN, 0);
      checkOutput("reset_cmd_data", P_CMD, 0);

      $display("[TB] write 0xE3");
      meas_val = 16'hABCD;
      i2cStart();
      sendAddr(DEV, 1'b0, hit);
      checkOutput("busy_after_match", P_BUSY, 1);
      sendData(8'hE3);
      i2cStop();
      checkOutput("busy_after_write_stop", P_BUSY, 0);
      checkOutput("cmd_data_e3", P_CMD, 8'hE3);

      $display("[TB] read two bytes, NACK last");
      i2cStart();
      sendAddr(DEV, 1'b1, hit);
      recvData(1'b1);
      recvData(1'b0);
      checkOutput("sda_released_after_nack", P_SDAEN, 0);
      i2cStop();
      checkOutput("busy_after_read_stop", P_BUSY, 0);

      $display("[TB] foreign address 0x45");
      watch_nodrive = 1'b1;
      i2cStart();
      sendAddr(7'h45, 1'b0, hit);
      checkOutput("busy_on_mismatch", P_BUSY, 0);
      i2cStop();
      watch_nodrive = 1'b0;
      checkOutput("no_drive_on_mismatch", P_NODRIVE, 0);

      $display("[TB] snapshot isolation");
      meas_val = 16'hABCD;
      i2cStart();
      sendAddr(DEV, 1'b1, hit);
      recvData(1'b1);
      meas_val = 16'h1234;
      recvData(1'b0);
      i2cStop();
      i2cStart();
      sendAddr(DEV, 1'b1, hit);
      recvData(1'b1);
      recvData(1'b0);
      i2cStop();

      $display("[TB] write then repeated START read with wrap");
      meas_val = 16'hABCD;
      i2cStart();
      sendAddr(DEV, 1'b0, hit);
      sendData(8'hF5);
      i2cStart();
      sendAddr(DEV, 1'b1, hit);
      recvData(1'b1);
      recvData(1'b1);
      recvData(1'b1);
      i2cStop();
      checkOutput("cmd_data_f5", P_CMD, 8'hF5);
      checkOutput("busy_after_rs_stop", P_BUSY, 0);

      $display("[TB] reset while driving a 0 bit");
      meas_val = 16'h00FF;
      i2cStart();
      sendAddr(DEV, 1'b1, hit);
      checkOutput("driving_zero_bit", P_SDAEN, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("sda_released_by_reset", P_SDAEN, 0);
      checkOutput("busy_cleared_by_reset", P_BUSY, 0);
      i2cStop();
      meas_val = 16'h5A3C;
      i2cStart();
      sendAddr(DEV, 1'b1, hit);
      recvData(1'b1);
      recvData(1'b0);
      i2cStop();

      $display("[TB] random transactions");
      for (int k = 0; k < 5; k++) begin
         logic       rd;
         logic [6:0] a;
         rd       = 1'($urandom_range(0, 1));
         a        = ($urandom_range(0, 4) == 0) ? 7'($urandom) : DEV;
         meas_val = 16'($urandom);
         applyStimulus(rd, a, int'($urandom_range(1, 3)));
      end

      final_strobe = 1'b1;
      tick();
      final_strobe = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
